// File: rtl/instr_sequencer_if.sv
// Load bus and instruction issue port between the instruction sequencer and its host/CPU.
// master = sequencer side (accepts loads, drives instructions); slave = host/CPU side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
) ();
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic [15:0]       instruction_out;
  logic              instruction_valid;

  modport master (
    input  load_en, load_addr, load_data,
    output instruction_out, instruction_valid
  );

  modport slave (
    output load_en, load_addr, load_data,
    input  instruction_out, instruction_valid
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction store and issue engine: streams preloaded 16-bit words until halt, end of memory or stop.
// Define INSTR_SEQ_LOOP_EN to wrap pc to 0 after the last word instead of finishing.
module instr_sequencer #(
  parameter int         DEPTH       = 16,
  parameter int         ADDR_W      = 4,
  parameter int         GAP         = 0,
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic                clk,
  input  logic                rst,
  instr_sequencer_if.master   bus,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   pc,
  output logic [15:0]         issued_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0]        GAP_LOAD  = 4'(GAP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       word;
  logic [ADDR_W-1:0] pc_n;
  logic [15:0]       cnt_n;
  logic [15:0]       out_n;
  logic              valid_n;
  logic [3:0]        gap_cnt, gap_n;

  assign word = mem[pc];

  // Program store has no reset so a reset mid-run keeps the loaded program.
  always_ff @(posedge clk) begin
    if (bus.load_en && state != RUN) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      pc                    <= '0;
      issued_cnt            <= '0;
      gap_cnt               <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      bus.instruction_out   <= '0;
      bus.instruction_valid <= 1'b0;
    end else begin
      state                 <= state_n;
      pc                    <= pc_n;
      issued_cnt            <= cnt_n;
      gap_cnt               <= gap_n;
      busy                  <= (state_n == RUN);
      done                  <= (state_n == DONE);
      bus.instruction_out   <= out_n;
      bus.instruction_valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = issued_cnt;
    gap_n   = gap_cnt;
    out_n   = bus.instruction_out;
    valid_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_n = RUN;
          pc_n    = '0;
          cnt_n   = '0;
          gap_n   = '0;
        end
      end
      RUN: begin
        // stop takes priority over any issue or gap countdown in the same cycle
        if (stop) begin
          state_n = IDLE;
        end else if (gap_cnt != 4'd0) begin
          gap_n = gap_cnt - 4'd1;
        end else if (word[15:10] == HALT_OPCODE) begin
          state_n = DONE;
        end else begin
          out_n   = word;
          valid_n = 1'b1;
          cnt_n   = (issued_cnt == 16'hFFFF) ? issued_cnt : issued_cnt + 16'd1;
          gap_n   = GAP_LOAD;
          if (pc == LAST_ADDR) begin
`ifdef INSTR_SEQ_LOOP_EN
            pc_n = '0;
`else
            state_n = DONE;
`endif
          end else begin
            pc_n = pc + ADDR_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: two instances (GAP=0 and GAP=2) run the same programs side by side.
// Loop-mode expectations are selected by INSTR_SEQ_LOOP_EN, matching the RTL build.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop0, stop1;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        busy0, busy1, done0, done1;
  logic [3:0]  pc0, pc1;
  logic [15:0] cnt0, cnt1;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last0      = 0;
  int last1      = 0;
  bit first1     = 1'b0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  instr_sequencer_if #(.ADDR_W(4)) bus0 ();
  instr_sequencer_if #(.ADDR_W(4)) bus1 ();

  assign bus0.load_en   = load_en;
  assign bus0.load_addr = load_addr;
  assign bus0.load_data = load_data;
  assign bus1.load_en   = load_en;
  assign bus1.load_addr = load_addr;
  assign bus1.load_data = load_data;

  instr_sequencer #(.DEPTH(16), .ADDR_W(4), .GAP(0), .HALT_OPCODE(6'h3F)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master), .start(start), .stop(stop0),
    .busy(busy0), .done(done0), .pc(pc0), .issued_cnt(cnt0)
  );

  instr_sequencer #(.DEPTH(16), .ADDR_W(4), .GAP(2), .HALT_OPCODE(6'h3F)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master), .start(start), .stop(stop1),
    .busy(busy1), .done(done1), .pc(pc1), .issued_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Every valid word must be the next scoreboard entry and arrive exactly GAP+1 cycles after the previous one.
  always @(negedge clk) begin
    if (!rst && bus0.instruction_valid) begin
      if (exp_q0.size() == 0) checkOutput("dut0_unexpected_valid", 32'd1, 32'd0);
      else checkOutput("dut0_word", 32'(bus0.instruction_out), 32'(exp_q0.pop_front()));
      checkOutput("dut0_spacing", 32'(cyc - last0), 32'd1);
      last0 = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.instruction_valid) begin
      if (exp_q1.size() == 0) checkOutput("dut1_unexpected_valid", 32'd1, 32'd0);
      else checkOutput("dut1_word", 32'(bus1.instruction_out), 32'(exp_q1.pop_front()));
      checkOutput("dut1_spacing", 32'(cyc - last1), first1 ? 32'd1 : 32'd3);
      last1  = cyc;
      first1 = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [3:0] addr, input logic [15:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic expectWord(input logic [15:0] w);
    exp_q0.push_back(w);
    exp_q1.push_back(w);
  endtask

  task automatic startRun();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    last0  = cyc;
    last1  = cyc;
    first1 = 1'b1;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done0 && done1) break;
    end
    @(negedge clk);
  endtask

  task automatic checkFinal(input string tag, input logic [15:0] exp_cnt, input logic [3:0] exp_pc,
                            input logic exp_done);
    checkOutput({tag, "_dut0_done"}, 32'(done0), 32'(exp_done));
    checkOutput({tag, "_dut1_done"}, 32'(done1), 32'(exp_done));
    checkOutput({tag, "_dut0_busy"}, 32'(busy0), 32'd0);
    checkOutput({tag, "_dut1_busy"}, 32'(busy1), 32'd0);
    checkOutput({tag, "_dut0_cnt"}, 32'(cnt0), 32'(exp_cnt));
    checkOutput({tag, "_dut1_cnt"}, 32'(cnt1), 32'(exp_cnt));
    checkOutput({tag, "_dut0_pc"}, 32'(pc0), 32'(exp_pc));
    checkOutput({tag, "_dut1_pc"}, 32'(pc1), 32'(exp_pc));
    checkOutput({tag, "_dut0_pending"}, 32'(exp_q0.size()), 32'd0);
    checkOutput({tag, "_dut1_pending"}, 32'(exp_q1.size()), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out"}, 32'(bus0.instruction_out), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus0.instruction_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy0), 32'd0);
    checkOutput({tag, "_done"}, 32'(done0), 32'd0);
    checkOutput({tag, "_pc"}, 32'(pc0), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(cnt0), 32'd0);
    checkOutput({tag, "_dut1_valid"}, 32'(bus1.instruction_valid), 32'd0);
    checkOutput({tag, "_dut1_busy"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop0 = 1'b0; stop1 = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] short program with halt");
    applyStimulus(4'd0, 16'h0401);
    applyStimulus(4'd1, 16'h0802);
    applyStimulus(4'd2, 16'hFC00);
    expectWord(16'h0401);
    expectWord(16'h0802);
    startRun();
    checkOutput("start_busy", 32'(busy0), 32'd1);
    waitDone(100);
    checkFinal("halt", 16'd2, 4'd2, 1'b1);

    $display("[TB] full memory without halt");
    for (int i = 0; i < 16; i++) applyStimulus(4'(i), 16'(16'h0400 + i));
`ifdef INSTR_SEQ_LOOP_EN
    for (int i = 0; i < 20; i++) expectWord(16'(16'h0400 + i % 16));
    startRun();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cnt0 == 16'd20) stop0 = 1'b1;
      if (cnt1 == 16'd20) stop1 = 1'b1;
      if (stop0 && stop1 && !busy0 && !busy1) break;
    end
    @(negedge clk);
    checkFinal("loop", 16'd20, 4'd4, 1'b0);
    stop0 = 1'b0;
    stop1 = 1'b0;
`else
    for (int i = 0; i < 16; i++) expectWord(16'(16'h0400 + i));
    startRun();
    waitDone(200);
    checkFinal("endmem", 16'd16, 4'd15, 1'b1);
`endif

    $display("[TB] load attempt while running");
    applyStimulus(4'd0, 16'h0401);
    applyStimulus(4'd1, 16'h0802);
    applyStimulus(4'd2, 16'hFC00);
    expectWord(16'h0401);
    expectWord(16'h0802);
    startRun();
    applyStimulus(4'd1, 16'hFC00);
    waitDone(100);
    checkFinal("runload", 16'd2, 4'd2, 1'b1);

    $display("[TB] reset during run");
    expectWord(16'h0401);
    expectWord(16'h0802);
    startRun();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.instruction_valid) break;
    end
    rst = 1'b1;
    @(negedge clk);
    checkResetState("midrst");
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();

    $display("[TB] start and stop together");
    start = 1'b1; stop0 = 1'b1; stop1 = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; stop0 = 1'b0; stop1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("startstop_dut0_busy", 32'(busy0), 32'd0);
    checkOutput("startstop_dut1_busy", 32'(busy1), 32'd0);
    checkOutput("startstop_dut0_valid", 32'(bus0.instruction_valid), 32'd0);

    $display("[TB] restart after reset keeps program");
    expectWord(16'h0401);
    expectWord(16'h0802);
    startRun();
    waitDone(100);
    checkFinal("restart", 16'd2, 4'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
